// File: rtl/integrate_and_dump_controller_pkg.sv
// Shared types and helpers for the integrate-and-dump controller: FSM state encoding,
// default widths and the signed-add overflow test.
package integrate_and_dump_controller_pkg;

    localparam int c_DATA_WIDTH  = 8;
    localparam int c_ACC_WIDTH   = 16;
    localparam int c_COUNT_WIDTH = 8;

    // 2'd3 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } idc_state_t;

    // Two's-complement add overflows when both operands share a sign the result lacks.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/integrate_and_dump_controller_if.sv
// Sample-in / frame-sum-out handshake bundle for the integrate-and-dump controller.
interface integrate_and_dump_controller_if
    import integrate_and_dump_controller_pkg::*;
#(
    parameter int p_DATA_WIDTH  = c_DATA_WIDTH,
    parameter int p_ACC_WIDTH   = c_ACC_WIDTH,
    parameter int p_COUNT_WIDTH = c_COUNT_WIDTH
);
    logic [p_COUNT_WIDTH-1:0]       i_LENGTH;
    logic                           i_VALID;
    logic                           o_READY;
    logic signed [p_DATA_WIDTH-1:0] i_SAMPLE;
    logic                           o_VALID;
    logic                           i_READY;
    logic signed [p_ACC_WIDTH-1:0]  o_SUM;
    logic                           o_OVERFLOW;
    logic                           o_BUSY;

    modport slave (
        input  i_LENGTH, i_VALID, i_SAMPLE, i_READY,
        output o_READY, o_VALID, o_SUM, o_OVERFLOW, o_BUSY
    );

    modport master (
        output i_LENGTH, i_VALID, i_SAMPLE, i_READY,
        input  o_READY, o_VALID, o_SUM, o_OVERFLOW, o_BUSY
    );
endinterface

// File: rtl/integrate_and_dump_controller_frame_counter.sv
// Frame-length latch and accepted-sample counter; flags the accept that completes a frame.
module idc_frame_counter #(
    parameter int p_COUNT_WIDTH = 8
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET_N,
    input  logic                     i_START,
    input  logic                     i_STEP,
    input  logic                     i_CLEAR,
    input  logic [p_COUNT_WIDTH-1:0] i_LENGTH,
    output logic                     o_LAST
);
    localparam logic [p_COUNT_WIDTH-1:0] c_ONE = {{(p_COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [p_COUNT_WIDTH-1:0] len_reg;
    logic [p_COUNT_WIDTH-1:0] count_reg;
    logic [p_COUNT_WIDTH-1:0] len_eff;

    // A zero length is treated as a single-sample frame.
    assign len_eff = (i_LENGTH == '0) ? c_ONE : i_LENGTH;

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            len_reg   <= '0;
            count_reg <= '0;
        end else if (i_START) begin
            len_reg   <= len_eff;
            count_reg <= c_ONE;
        end else if (i_STEP) begin
            count_reg <= count_reg + c_ONE;
        end else if (i_CLEAR) begin
            count_reg <= '0;
        end
    end

    // On the first accept the latched length is not yet valid, so decide from len_eff.
    assign o_LAST = i_START ? (len_eff == c_ONE) : (count_reg == len_reg - c_ONE);

endmodule

// File: rtl/integrate_and_dump_controller.sv
// Integrate-and-dump stage: sums N signed samples per frame and hands the frame sum
// and its overflow flag to a downstream consumer over valid/ready.
module integrate_and_dump_controller
    import integrate_and_dump_controller_pkg::*;
#(
    parameter int p_DATA_WIDTH  = c_DATA_WIDTH,
    parameter int p_ACC_WIDTH   = c_ACC_WIDTH,
    parameter int p_COUNT_WIDTH = c_COUNT_WIDTH
) (
    input logic                             i_CLK,
    input logic                             i_RESET_N,
    integrate_and_dump_controller_if.slave  bus
);
    idc_state_t state_reg;
    idc_state_t state_next;

    logic signed [p_ACC_WIDTH-1:0] acc_reg;
    logic signed [p_ACC_WIDTH-1:0] acc_next;
    logic signed [p_ACC_WIDTH-1:0] add_result;
    logic signed [p_ACC_WIDTH-1:0] sample_ext;
    logic signed [p_ACC_WIDTH-1:0] sum_reg;
    logic                          ovf_reg;
    logic                          ovf_next;
    logic                          ovf_out_reg;

    logic ready_int;
    logic in_idle;
    logic accept;
    logic emit;
    logic last_sample;

    assign sample_ext = p_ACC_WIDTH'(signed'(bus.i_SAMPLE));
    assign in_idle    = (state_reg == IDLE);
    assign ready_int  = (state_reg == IDLE) || (state_reg == ACCUM);
    assign accept     = bus.i_VALID && ready_int;
    assign emit       = (state_reg == DUMP) && bus.i_READY;

    idc_frame_counter #(
        .p_COUNT_WIDTH (p_COUNT_WIDTH)
    ) u_frame_counter (
        .i_CLK     (i_CLK),
        .i_RESET_N (i_RESET_N),
        .i_START   (accept && in_idle),
        .i_STEP    (accept && (state_reg == ACCUM)),
        .i_CLEAR   (emit),
        .i_LENGTH  (bus.i_LENGTH),
        .o_LAST    (last_sample)
    );

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = last_sample ? DUMP : ACCUM;
            ACCUM:   if (accept && last_sample) state_next = DUMP;
            DUMP:    if (emit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        add_result = acc_reg + sample_ext;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        if (accept) begin
            if (in_idle) begin
                acc_next = sample_ext;
                ovf_next = 1'b0;
            end else begin
                acc_next = add_result;
                ovf_next = ovf_reg | add_overflow(acc_reg[p_ACC_WIDTH-1], sample_ext[p_ACC_WIDTH-1],
                                                  add_result[p_ACC_WIDTH-1]);
            end
        end else if (emit) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end
    end

    // sum_reg is loaded only on the frame-completing accept, so it stays put through a stall
    // and keeps the last frame's value while the next frame builds.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            sum_reg     <= '0;
            ovf_out_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            if (accept && last_sample) begin
                sum_reg     <= acc_next;
                ovf_out_reg <= ovf_next;
            end else if (emit) begin
                ovf_out_reg <= 1'b0;
            end
        end
    end

    assign bus.o_READY    = ready_int && i_RESET_N;
    assign bus.o_VALID    = (state_reg == DUMP);
    assign bus.o_SUM      = sum_reg;
    assign bus.o_OVERFLOW = ovf_out_reg;
    assign bus.o_BUSY     = (state_reg != IDLE);

    a_no_ready_and_valid: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
        !(bus.o_READY && bus.o_VALID));
    a_legal_state: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
        (2'(state_reg) != 2'd3));
    a_stable_under_stall: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
        (bus.o_VALID && !bus.i_READY) |=> (bus.o_VALID && $stable(bus.o_SUM)));

endmodule

// File: tb/tb_integrate_and_dump_controller.sv
// Directed bench: a per-cycle vector table plus hand sequences for stall, wrap and reset.
module tb_integrate_and_dump_controller;

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic              rdy;
    logic signed [7:0] sample;
    logic [7:0]        length;

    int n_cmp = 0;
    int n_bad = 0;

    integrate_and_dump_controller_if #(.p_DATA_WIDTH(8), .p_ACC_WIDTH(16), .p_COUNT_WIDTH(8)) bus16 ();
    integrate_and_dump_controller_if #(.p_DATA_WIDTH(8), .p_ACC_WIDTH(8),  .p_COUNT_WIDTH(8)) bus8 ();

    assign bus16.i_VALID  = valid;
    assign bus16.i_SAMPLE = sample;
    assign bus16.i_LENGTH = length;
    assign bus16.i_READY  = rdy;
    assign bus8.i_VALID   = valid;
    assign bus8.i_SAMPLE  = sample;
    assign bus8.i_LENGTH  = length;
    assign bus8.i_READY   = rdy;

    integrate_and_dump_controller #(.p_DATA_WIDTH(8), .p_ACC_WIDTH(16), .p_COUNT_WIDTH(8)) dut16 (
        .i_CLK     (clk),
        .i_RESET_N (rst_n),
        .bus       (bus16.slave)
    );

    integrate_and_dump_controller #(.p_DATA_WIDTH(8), .p_ACC_WIDTH(8), .p_COUNT_WIDTH(8)) dut8 (
        .i_CLK     (clk),
        .i_RESET_N (rst_n),
        .bus       (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   s;
        int   len;
        logic rdy;
        logic e_rdy;
        logic e_vld;
        int   e_sum;
        logic e_ovf;
        logic e_busy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic v, input int s, input int len, input logic r,
                                input logic er, input logic ev, input int es, input logic eo,
                                input logic eb);
        vec_t t;
        t.v = v; t.s = s; t.len = len; t.rdy = r;
        t.e_rdy = er; t.e_vld = ev; t.e_sum = es; t.e_ovf = eo; t.e_busy = eb;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input int len, input logic r);
        valid  = v;
        sample = 8'(s);
        length = 8'(len);
        rdy    = r;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check16(input string tag, input logic er, input logic ev, input int es,
                           input logic eo, input logic eb);
        check({tag, ".ready"}, int'(bus16.o_READY), int'(er));
        check({tag, ".valid"}, int'(bus16.o_VALID), int'(ev));
        check({tag, ".sum"},   int'(bus16.o_SUM),   es);
        check({tag, ".ovf"},   int'(bus16.o_OVERFLOW), int'(eo));
        check({tag, ".busy"},  int'(bus16.o_BUSY),  int'(eb));
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n = 0;
        while (bus16.o_VALID !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus16.o_VALID !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: o_VALID still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    initial begin
        // L=4 back-to-back; L=3 with gaps and mid-frame length changes; L=0 and L=1 frames.
        vecs[0]  = mk(1,  1, 4, 1,  1, 0,  0, 0, 0);
        vecs[1]  = mk(1,  2, 4, 1,  1, 0,  0, 0, 1);
        vecs[2]  = mk(1,  3, 4, 1,  1, 0,  0, 0, 1);
        vecs[3]  = mk(1,  4, 4, 1,  1, 0,  0, 0, 1);
        vecs[4]  = mk(0,  0, 4, 1,  0, 1, 10, 0, 1);
        vecs[5]  = mk(0,  0, 4, 1,  1, 0, 10, 0, 0);
        vecs[6]  = mk(1, -5, 3, 1,  1, 0, 10, 0, 0);
        vecs[7]  = mk(0,  0, 1, 1,  1, 0, 10, 0, 1);
        vecs[8]  = mk(0,  0, 1, 1,  1, 0, 10, 0, 1);
        vecs[9]  = mk(1,  7, 1, 1,  1, 0, 10, 0, 1);
        vecs[10] = mk(0,  0, 2, 1,  1, 0, 10, 0, 1);
        vecs[11] = mk(0,  0, 2, 1,  1, 0, 10, 0, 1);
        vecs[12] = mk(1, -8, 2, 1,  1, 0, 10, 0, 1);
        vecs[13] = mk(0,  0, 0, 1,  0, 1, -6, 0, 1);
        vecs[14] = mk(0,  0, 0, 1,  1, 0, -6, 0, 0);
        vecs[15] = mk(1, 42, 0, 1,  1, 0, -6, 0, 0);
        vecs[16] = mk(0,  0, 0, 1,  0, 1, 42, 0, 1);
        vecs[17] = mk(1, 17, 1, 1,  1, 0, 42, 0, 0);
        vecs[18] = mk(0,  0, 1, 1,  0, 1, 17, 0, 1);
        vecs[19] = mk(0,  0, 1, 1,  1, 0, 17, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check16("reset", 0, 0, 0, 0, 0);
        $display("reset: ready=%0d valid=%0d sum=%0d", bus16.o_READY, bus16.o_VALID, bus16.o_SUM);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].len, vecs[i].rdy);
            #1;
            check16($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_sum,
                    vecs[i].e_ovf, vecs[i].e_busy);
            $display("vec %0d: v=%0d s=%0d L=%0d -> ready=%0d valid=%0d sum=%0d", i, vecs[i].v,
                     vecs[i].s, vecs[i].len, bus16.o_READY, bus16.o_VALID, bus16.o_SUM);
            tick();
        end

        // Consumer stalls 5 cycles in DUMP while the source keeps offering 99.
        drive(1, 5, 2, 0); tick();
        drive(1, 6, 2, 0); tick();
        drive(1, 99, 2, 0);
        for (int i = 0; i < 5; i++) begin
            check16($sformatf("stall%0d", i), 0, 1, 11, 0, 1);
            $display("stall %0d: valid=%0d ready=%0d sum=%0d", i, bus16.o_VALID, bus16.o_READY, bus16.o_SUM);
            tick();
        end
        drive(1, 99, 2, 1);
        #1;
        check16("stall_emit", 0, 1, 11, 0, 1);
        tick();
        drive(1, 3, 2, 1);
        check16("after_stall_idle", 1, 0, 11, 0, 0);
        tick();
        drive(1, 4, 2, 1); tick();
        drive(0, 0, 2, 1);
        check16("after_stall_frame", 0, 1, 7, 0, 1);
        $display("post-stall frame: sum=%0d", bus16.o_SUM);
        tick();

        // 100+100 wraps in an 8-bit accumulator but not in the 16-bit one.
        drive(1, 100, 2, 1); tick();
        drive(1, 100, 2, 1); tick();
        drive(0, 0, 2, 1);
        check("wrap8.valid", int'(bus8.o_VALID), 1);
        check("wrap8.sum", int'(bus8.o_SUM), -56);
        check("wrap8.ovf", int'(bus8.o_OVERFLOW), 1);
        check("wrap16.sum", int'(bus16.o_SUM), 200);
        check("wrap16.ovf", int'(bus16.o_OVERFLOW), 0);
        $display("wrap frame: sum8=%0d ovf8=%0d sum16=%0d", bus8.o_SUM, bus8.o_OVERFLOW, bus16.o_SUM);
        tick();
        check("wrap8.ovf_after_emit", int'(bus8.o_OVERFLOW), 0);
        check("wrap8.valid_after_emit", int'(bus8.o_VALID), 0);
        drive(1, 1, 2, 1); tick();
        drive(1, 1, 2, 1); tick();
        drive(0, 0, 2, 1);
        check("nowrap8.sum", int'(bus8.o_SUM), 2);
        check("nowrap8.ovf", int'(bus8.o_OVERFLOW), 0);
        $display("frame 1+1: sum8=%0d ovf8=%0d", bus8.o_SUM, bus8.o_OVERFLOW);
        tick();

        // Reset after the 2nd sample of an L=4 frame discards the partial sum.
        drive(1, 5, 4, 1); tick();
        drive(1, 6, 4, 1); tick();
        drive(0, 0, 4, 1);
        rst_n = 1'b0;
        #1;
        check16("midreset", 0, 0, 0, 0, 0);
        check("midreset8.sum", int'(bus8.o_SUM), 0);
        $display("mid-frame reset: ready=%0d busy=%0d sum=%0d", bus16.o_READY, bus16.o_BUSY, bus16.o_SUM);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check16("after_reset", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4, 1);
            tick();
        end
        drive(0, 0, 4, 1);
        wait_valid("reset_frame.timeout", 10);
        check("reset_frame.sum", int'(bus16.o_SUM), 4);
        check("reset_frame.ovf", int'(bus16.o_OVERFLOW), 0);
        $display("post-reset frame: sum=%0d", bus16.o_SUM);
        tick();
        check16("final_idle", 1, 0, 4, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
